// File: rtl/uart_core.sv
// uart_core: full-duplex UART with a valid/ready byte stream on each side.
// The transmitter serialises start, data (LSB first), optional parity and stop bits.
// The receiver synchronises the line, qualifies the start bit at its centre,
// samples every bit centre, and presents each character with error flags.

module uart_core #(
  parameter int CLOCK_SPEED = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  // Counter wide enough for 0..CLKS_PER_BIT-1; the floor of 2 only matters for
  // illegal settings, which are rejected below anyway.
  localparam int CNT_W = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
  localparam int BIT_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Transmitter states
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  // Receiver states
  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PARITY    = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  // Reject configurations the timing and framing logic cannot honour.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks
      $error("uart_core: CLOCK_SPEED / BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_core: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_core: STOP_BITS must be 1 or 2");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  logic [2:0]           tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_bit_end;
  logic                 tx_par_calc;

  assign tx_ready    = (tx_state_q == TX_IDLE);
  assign uart_tx     = tx_line_q;
  assign tx_bit_end  = (tx_cnt_q == CNT_LAST);
  assign tx_par_calc = (PARITY == 1) ? ~^tx_data : ^tx_data;

  // Next-state logic: each line bit value is registered on entry to that bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;

    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    end

    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = tx_par_calc;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d = '0;
            if (PARITY != 0) begin
              tx_line_d  = tx_par_q;
              tx_state_d = TX_PARITY;
            end else begin
              tx_line_d  = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_bit_d  = tx_bit_q + 1'b1;
            tx_line_d = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_line_d  = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_q == STOP_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: begin
        tx_line_d  = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // Transmitter registers; reset forces the line idle-high at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]           rx_sync_q, rx_sync_d;
  logic                 rxs;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_fperr_q, rx_fperr_d;
  logic                 rx_fferr_q, rx_fferr_d;
  logic                 rx_load_q, rx_load_d;
  logic                 rx_bit_end;
  logic                 rx_par_exp;

  assign rx_sync_d  = {rx_sync_q[0], uart_rx};
  assign rxs        = rx_sync_q[1];
  assign rx_bit_end = (rx_cnt_q == CNT_LAST);
  assign rx_par_exp = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;

  // Frame decoder: qualify the start bit at mid-bit, then sample every bit centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_fperr_d = rx_fperr_q;
    rx_fferr_d = rx_fferr_q;
    rx_load_d  = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rxs) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxs ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_fperr_d = rxs ^ rx_par_exp;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_fferr_d = ~rxs;
          rx_load_d  = 1'b1;
          rx_state_d = rxs ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rxs) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Synchroniser and frame decoder registers; the synchroniser resets to idle-high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_fperr_q <= 1'b0;
      rx_fferr_q <= 1'b0;
      rx_load_q  <= 1'b0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_fperr_q <= rx_fperr_d;
      rx_fferr_q <= rx_fferr_d;
      rx_load_q  <= rx_load_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive output register
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_take;

  assign rx_take       = rx_valid_q & rx_ready;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

  // Load a finished frame if the slot is free or being emptied, otherwise flag overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;

    if (rx_load_q) begin
      if (!rx_valid_q || rx_take) begin
        rx_data_d  = rx_shift_q;
        rx_perr_d  = rx_fperr_q;
        rx_ferr_d  = rx_fferr_q;
        rx_valid_d = 1'b1;
        if (rx_take) begin
          rx_ovr_d = 1'b0;
        end
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (rx_take) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
  end

  // Output holding registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed bench for uart_core with three instances sharing one clock
// and reset: A = 8N1 (bench-driven rx line), B = 8E2 in loopback, C = 8O1.
// Expected characters go into scoreboard queues when stimulus is applied and are
// popped when the DUT presents a character.

module tb_uart_core;

  logic clock;
  logic reset_n;

  // Instance A: 8N1
  logic       a_uart_rx, a_uart_tx;
  logic [7:0] a_tx_data, a_rx_data;
  logic       a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
  logic       a_perr, a_ferr, a_ovr;

  // Instance B: 8E2, uart_tx looped back into uart_rx
  logic       b_uart_tx;
  logic [7:0] b_tx_data, b_rx_data;
  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
  logic       b_perr, b_ferr, b_ovr;

  // Instance C: 8O1
  logic       c_uart_rx, c_uart_tx;
  logic [7:0] c_tx_data, c_rx_data;
  logic       c_tx_valid, c_tx_ready, c_rx_valid, c_rx_ready;
  logic       c_perr, c_ferr, c_ovr;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } rx_exp_t;

  rx_exp_t    rx_exp_q[$];
  rx_exp_t    b_exp_q[$];
  logic [7:0] tx_exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int b_valid_cnt = 0;

  uart_core #(.CLOCK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .uart_rx(a_uart_rx), .uart_tx(a_uart_tx),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_overrun(a_ovr)
  );

  uart_core #(.CLOCK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .uart_rx(b_uart_tx), .uart_tx(b_uart_tx),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_overrun(b_ovr)
  );

  uart_core #(.CLOCK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .uart_rx(c_uart_rx), .uart_tx(c_uart_tx),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
    .rx_parity_err(c_perr), .rx_frame_err(c_ferr), .rx_overrun(c_ovr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Build start + 8 data bits (+ parity) + stop, LSB first in bit 0.
  function automatic logic [15:0] build_frame(input logic [7:0] d, input logic has_par,
                                              input logic par, input logic stop);
    logic [15:0] f;
    f      = 16'hFFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (has_par) begin
      f[9]  = par;
      f[10] = stop;
    end else begin
      f[9] = stop;
    end
    return f;
  endfunction

  // Drive a serial frame onto the rx line of instance A (inst 0) or C (inst 2).
  task automatic apply_stimulus(input int inst, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (inst == 0) a_uart_rx = bits[i];
      else           c_uart_rx = bits[i];
      tick(16);
    end
  endtask

  // Bounded wait for rx_valid on A or C.
  task automatic wait_rx_valid(input int inst);
    int guard;
    guard = 0;
    while (((inst == 0) ? a_rx_valid : c_rx_valid) !== 1'b1 && guard < 64) begin
      tick(1);
      guard++;
    end
    if (guard >= 64) check_output("rx_valid_timeout", 32'(guard), 0);
  endtask

  // Pop the expected character and compare it with the held output of A or C.
  task automatic check_rx(input int inst);
    rx_exp_t    e;
    logic [7:0] d;
    logic       v, p, f, o;
    if (rx_exp_q.size() == 0) begin
      check_output("rx_scoreboard_empty", 1, 0);
      return;
    end
    e = rx_exp_q.pop_front();
    if (inst == 0) begin
      v = a_rx_valid; d = a_rx_data; p = a_perr; f = a_ferr; o = a_ovr;
    end else begin
      v = c_rx_valid; d = c_rx_data; p = c_perr; f = c_ferr; o = c_ovr;
    end
    check_output("rx_valid", 32'(v), 1);
    check_output("rx_data", 32'(d), 32'(e.data));
    check_output("rx_parity_err", 32'(p), 32'(e.perr));
    check_output("rx_frame_err", 32'(f), 32'(e.ferr));
    check_output("rx_overrun", 32'(o), 32'(e.ovr));
  endtask

  // Watch A's uart_tx for one 8N1 frame starting the cycle after the handshake.
  task automatic check_tx_frame_a(output int ready_low);
    logic [7:0] d;
    logic [9:0] bits;
    int         hits;
    d         = tx_exp_q.pop_front();
    bits      = {1'b1, d, 1'b0};
    ready_low = 0;
    for (int b = 0; b < 10; b++) begin
      hits = 0;
      for (int c = 0; c < 16; c++) begin
        if (a_uart_tx === bits[b]) hits++;
        if (a_tx_ready === 1'b0) ready_low++;
        tick(1);
      end
      check_output($sformatf("tx_%02h_bit%0d_cycles", d, b), 32'(hits), 16);
    end
  endtask

  // Loopback monitor for B: every consumed character is checked against the scoreboard.
  always @(negedge clock) begin
    rx_exp_t e;
    if (reset_n && b_rx_valid) begin
      b_valid_cnt++;
      if (b_rx_ready) begin
        if (b_exp_q.size() == 0) begin
          check_output("b_rx_unexpected", 32'(b_rx_data), 0);
        end else begin
          e = b_exp_q.pop_front();
          check_output("b_rx_data", 32'(b_rx_data), 32'(e.data));
          check_output("b_rx_parity_err", 32'(b_perr), 32'(e.perr));
          check_output("b_rx_frame_err", 32'(b_ferr), 32'(e.ferr));
          check_output("b_rx_overrun", 32'(b_ovr), 32'(e.ovr));
        end
      end
    end
  end

  initial begin
    int rl;
    int cnt;
    int guard;

    reset_n    = 1'b0;
    a_uart_rx  = 1'b1; a_tx_data = '0; a_tx_valid = 1'b0; a_rx_ready = 1'b0;
    b_tx_data  = '0;   b_tx_valid = 1'b0; b_rx_ready = 1'b0;
    c_uart_rx  = 1'b1; c_tx_data = '0; c_tx_valid = 1'b0; c_rx_ready = 1'b0;

    // Reset values
    tick(3);
    check_output("reset_uart_tx", 32'(a_uart_tx), 1);
    check_output("reset_tx_ready", 32'(a_tx_ready), 1);
    check_output("reset_rx_valid", 32'(a_rx_valid), 0);
    check_output("reset_rx_data", 32'(a_rx_data), 0);
    check_output("reset_err_flags", 32'({a_perr, a_ferr, a_ovr}), 0);
    reset_n = 1'b1;
    tick(2);

    // 8N1 transmit of 0xA5 then 0x5A presented back-to-back
    $display("[TB] tx 0xA5 / 0x5A");
    a_tx_data = 8'hA5; a_tx_valid = 1'b1;
    tick(1);
    tx_exp_q.push_back(8'hA5);
    tx_exp_q.push_back(8'h5A);
    a_tx_data = 8'h5A;
    check_tx_frame_a(rl);
    check_output("tx_ready_low_cycles_a5", 32'(rl), 160);
    check_output("tx_ready_after_frame", 32'(a_tx_ready), 1);
    check_output("tx_line_idle_after_frame", 32'(a_uart_tx), 1);
    tick(1);
    a_tx_valid = 1'b0;
    check_tx_frame_a(rl);
    check_output("tx_ready_low_cycles_5a", 32'(rl), 160);

    // Loopback 8E2: 0x3C then 0xFF with rx_ready held high
    $display("[TB] loopback 8E2");
    b_rx_ready = 1'b1;
    b_exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    b_exp_q.push_back('{data: 8'hFF, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    b_tx_data = 8'h3C; b_tx_valid = 1'b1;
    tick(1);
    b_tx_data = 8'hFF;
    guard = 0;
    while (b_tx_ready !== 1'b1 && guard < 400) begin tick(1); guard++; end
    if (guard >= 400) check_output("b_tx_ready_timeout", 32'(guard), 0);
    tick(1);
    b_tx_valid = 1'b0;
    guard = 0;
    while (b_tx_ready !== 1'b1 && guard < 400) begin tick(1); guard++; end
    if (guard >= 400) check_output("b_tx_ready_timeout2", 32'(guard), 0);
    tick(40);
    check_output("b_rx_valid_cycles", 32'(b_valid_cnt), 2);
    check_output("b_scoreboard_drained", 32'(b_exp_q.size()), 0);

    // Odd parity on C: wrong parity bit then correct parity bit
    $display("[TB] odd parity check");
    rx_exp_q.push_back('{data: 8'h01, perr: 1'b1, ferr: 1'b0, ovr: 1'b0});
    apply_stimulus(2, build_frame(8'h01, 1'b1, 1'b1, 1'b1), 11);
    wait_rx_valid(2);
    check_rx(2);
    c_rx_ready = 1'b1; tick(1); c_rx_ready = 1'b0;
    check_output("c_rx_valid_cleared", 32'(c_rx_valid), 0);
    tick(8);
    rx_exp_q.push_back('{data: 8'h01, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    apply_stimulus(2, build_frame(8'h01, 1'b1, 1'b0, 1'b1), 11);
    wait_rx_valid(2);
    check_rx(2);
    c_rx_ready = 1'b1; tick(1); c_rx_ready = 1'b0;

    // Framing error on A: stop bit low, line then held low
    $display("[TB] frame error and break");
    rx_exp_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
    apply_stimulus(0, build_frame(8'h55, 1'b0, 1'b0, 1'b0), 10);
    a_uart_rx = 1'b0;
    wait_rx_valid(0);
    check_rx(0);
    a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 99; i++) begin
      if (a_rx_valid === 1'b1) cnt++;
      tick(1);
    end
    a_uart_rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (a_rx_valid === 1'b1) cnt++;
      tick(1);
    end
    check_output("break_extra_valid_cycles", 32'(cnt), 0);
    rx_exp_q.push_back('{data: 8'h12, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    apply_stimulus(0, build_frame(8'h12, 1'b0, 1'b0, 1'b1), 10);
    wait_rx_valid(0);
    check_rx(0);
    a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;

    // Overrun on A: two frames without consuming the first
    $display("[TB] overrun");
    rx_exp_q.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0, ovr: 1'b1});
    apply_stimulus(0, build_frame(8'h11, 1'b0, 1'b0, 1'b1), 10);
    apply_stimulus(0, build_frame(8'h22, 1'b0, 1'b0, 1'b1), 10);
    wait_rx_valid(0);
    check_rx(0);
    a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;
    check_output("overrun_rx_valid_cleared", 32'(a_rx_valid), 0);
    check_output("overrun_flag_cleared", 32'(a_ovr), 0);

    // Short low glitch must not start a frame; a real frame afterwards still works
    $display("[TB] glitch rejection");
    tick(8);
    a_uart_rx = 1'b0; tick(4); a_uart_rx = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_rx_valid === 1'b1) cnt++;
      tick(1);
    end
    check_output("glitch_valid_cycles", 32'(cnt), 0);
    rx_exp_q.push_back('{data: 8'h33, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    apply_stimulus(0, build_frame(8'h33, 1'b0, 1'b0, 1'b1), 10);
    wait_rx_valid(0);
    check_rx(0);
    a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;

    // Reset during data bit 3 of a transmit, then a clean 0x7E frame
    $display("[TB] reset mid-frame");
    a_tx_data = 8'h96; a_tx_valid = 1'b1;
    tick(1);
    a_tx_valid = 1'b0;
    tick(72);
    check_output("midframe_line_bit3", 32'(a_uart_tx), 0);
    check_output("midframe_tx_ready", 32'(a_tx_ready), 0);
    reset_n = 1'b0;
    #1;
    check_output("reset_async_uart_tx", 32'(a_uart_tx), 1);
    check_output("reset_async_tx_ready", 32'(a_tx_ready), 1);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    a_tx_data = 8'h7E; a_tx_valid = 1'b1;
    tick(1);
    a_tx_valid = 1'b0;
    tx_exp_q.push_back(8'h7E);
    check_tx_frame_a(rl);
    check_output("tx_ready_low_cycles_7e", 32'(rl), 160);
    check_output("tx_ready_after_7e", 32'(a_tx_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
